qsys_sdram_cpu_oci_dct_capture: RTL and testbench

Parametrised debug-capture-trace (DCT) buffer for the CPU OCI block. It records trace words into a circular buffer of configurable width and depth, with a selectable wrap or stop-on-full mode. On test_ending it captures a programmable number of post-trigger words, then freezes and raises test_has_ended. After that, the buffer is drained oldest-first through a one-cycle-latency read port by the debug or testbench side.

---
 rtl/qsys_sdram_cpu_oci_dct_capture.sv | 126 ++++++++++++
 tb/tb_qsys_sdram_cpu_oci_dct_capture.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/qsys_sdram_cpu_oci_dct_capture.sv
// Debug-capture-trace buffer: circular trace store with wrap/stop-on-full,
// post-trigger capture window, then freeze and oldest-first drain.
module qsys_sdram_cpu_oci_dct_capture #(
  parameter int DCT_WIDTH = 30,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       arm,
  input  logic                       mode_wrap,
  input  logic                       dct_valid,
  input  logic [DCT_WIDTH-1:0]       dct_word,
  input  logic                       test_ending,
  input  logic                       rd_en,
  output logic [DCT_WIDTH-1:0]       rd_data,
  output logic                       rd_valid,
  output logic [DCT_WIDTH-1:0]       dct_buffer,
  output logic [$clog2(DEPTH):0]     dct_count,
  output logic                       overflow,
  output logic                       test_has_ended,
  output logic [1:0]                 state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = 1;
  localparam logic [AW:0]   CNT_ONE   = 1;
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   POST_INIT = (AW+1)'(POST_TRIG);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_POST    = 2'd2,
    S_ENDED   = 2'd3
  } st_t;

  st_t                  st;
  logic [DCT_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          post_cnt;
  logic                 full, capturing, mem_we;

  assign state     = st;
  assign full      = (dct_count == CNT_FULL);
  assign capturing = (st == S_CAPTURE) || (st == S_POST);
  // A full buffer only accepts the word when overwriting the oldest entry
  assign mem_we    = !arm && capturing && dct_valid && (!full || mode_wrap);

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr] <= dct_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st             <= S_IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      dct_count      <= '0;
      post_cnt       <= '0;
      rd_data        <= '0;
      dct_buffer     <= '0;
      rd_valid       <= 1'b0;
      overflow       <= 1'b0;
      test_has_ended <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (arm) begin
        st             <= S_CAPTURE;
        wr_ptr         <= '0;
        rd_ptr         <= '0;
        dct_count      <= '0;
        post_cnt       <= '0;
        overflow       <= 1'b0;
        test_has_ended <= 1'b0;
      end else begin
        case (st)
          S_CAPTURE, S_POST: begin
            if (dct_valid) begin
              if (!full) begin
                wr_ptr     <= wr_ptr + PTR_ONE;
                dct_count  <= dct_count + CNT_ONE;
                dct_buffer <= dct_word;
              end else if (mode_wrap) begin
                wr_ptr     <= wr_ptr + PTR_ONE;
                rd_ptr     <= rd_ptr + PTR_ONE;
                dct_buffer <= dct_word;
                overflow   <= 1'b1;
              end else begin
                overflow   <= 1'b1;
              end
            end
            // Trigger-cycle word is pre-trigger; dropped words still burn the window
            if (st == S_CAPTURE) begin
              if (test_ending) begin
                if (POST_TRIG == 0) begin
                  st             <= S_ENDED;
                  test_has_ended <= 1'b1;
                end else begin
                  st       <= S_POST;
                  post_cnt <= POST_INIT;
                end
              end
            end else if (dct_valid) begin
              post_cnt <= post_cnt - CNT_ONE;
              if (post_cnt == CNT_ONE) begin
                st             <= S_ENDED;
                test_has_ended <= 1'b1;
              end
            end
          end
          S_ENDED: begin
            if (rd_en && (dct_count != '0)) begin
              rd_data   <= mem[rd_ptr];
              rd_valid  <= 1'b1;
              rd_ptr    <= rd_ptr + PTR_ONE;
              dct_count <= dct_count - CNT_ONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qsys_sdram_cpu_oci_dct_capture.sv
// Directed bench for the DCT capture buffer: fill/trigger/drain scenarios,
// wrap vs stop modes, re-arm mid-window and async reset mid-drain.
module tb_qsys_sdram_cpu_oci_dct_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        arm = 1'b0, mode_wrap = 1'b0, dct_valid = 1'b0;
  logic [29:0] dct_word = '0;
  logic        test_ending = 1'b0, rd_en = 1'b0;
  logic [29:0] rd_data, dct_buffer;
  logic        rd_valid, overflow, test_has_ended;
  logic [4:0]  dct_count;
  logic [1:0]  state;

  int total = 0;
  int bad   = 0;

  qsys_sdram_cpu_oci_dct_capture #(.DCT_WIDTH(30), .DEPTH(16), .POST_TRIG(4)) dut (
    .clk(clk), .reset(reset), .arm(arm), .mode_wrap(mode_wrap),
    .dct_valid(dct_valid), .dct_word(dct_word), .test_ending(test_ending),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .dct_buffer(dct_buffer), .dct_count(dct_count), .overflow(overflow),
    .test_has_ended(test_has_ended), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic wr(input logic [29:0] w);
    dct_valid = 1'b1; dct_word = w; tick(); dct_valid = 1'b0;
  endtask

  task automatic trig();
    test_ending = 1'b1; tick(); test_ending = 1'b0;
  endtask

  // back-to-back pops expecting first, first+1, ...
  task automatic drain(input string tag, input int first, input int n);
    rd_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      chk({tag, "_vld"}, 32'(rd_valid), 32'd1);
      chk({tag, "_dat"}, 32'(rd_data), 32'(first + i));
    end
    rd_en = 1'b0;
  endtask

  initial begin
    // reset values
    #12;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_cnt", 32'(dct_count), 32'd0);
    chk("rst_vld", 32'(rd_valid), 32'd0);
    chk("rst_ended", 32'(test_has_ended), 32'd0);
    chk("rst_buf", 32'(dct_buffer), 32'd0);
    @(negedge clk); reset = 1'b0;
    tick();

    // IDLE ignores writes
    wr(30'h3);
    chk("idle_cnt", 32'(dct_count), 32'd0);

    // 1: basic stop-mode capture
    mode_wrap = 1'b0;
    do_arm();
    chk("t1_state", 32'(state), 32'd1);
    for (int i = 0; i <= 4; i++) wr(30'(i));
    trig();
    chk("t1_post", 32'(state), 32'd2);
    for (int i = 5; i <= 7; i++) wr(30'(i));
    chk("t1_still_post", 32'(state), 32'd2);
    wr(30'h8);
    chk("t1_ended_st", 32'(state), 32'd3);
    chk("t1_ended", 32'(test_has_ended), 32'd1);
    chk("t1_cnt", 32'(dct_count), 32'd9);
    chk("t1_ovf", 32'(overflow), 32'd0);
    chk("t1_buf", 32'(dct_buffer), 32'h8);
    wr(30'h99);
    chk("t1_wr_ignored", 32'(dct_count), 32'd9);
    drain("t1_pop", 0, 9);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("t1_empty_vld", 32'(rd_valid), 32'd0);
    chk("t1_empty_hold", 32'(rd_data), 32'h8);
    chk("t1_empty_cnt", 32'(dct_count), 32'd0);

    // 2: wrap mode keeps newest 16
    mode_wrap = 1'b1;
    do_arm();
    chk("t2_arm_cnt", 32'(dct_count), 32'd0);
    for (int i = 0; i < 20; i++) wr(30'(i));
    trig();
    for (int i = 20; i < 24; i++) wr(30'(i));
    chk("t2_state", 32'(state), 32'd3);
    chk("t2_cnt", 32'(dct_count), 32'd16);
    chk("t2_ovf", 32'(overflow), 32'd1);
    chk("t2_buf", 32'(dct_buffer), 32'd23);
    drain("t2_pop", 8, 16);

    // 3: stop mode keeps oldest 16; dropped post words still count
    mode_wrap = 1'b0;
    do_arm();
    chk("t3_ovf_clr", 32'(overflow), 32'd0);
    for (int i = 0; i < 20; i++) wr(30'(i));
    chk("t3_buf_hold", 32'(dct_buffer), 32'd15);
    trig();
    for (int i = 20; i < 23; i++) wr(30'(i));
    chk("t3_post", 32'(state), 32'd2);
    wr(30'd23);
    chk("t3_state", 32'(state), 32'd3);
    chk("t3_cnt", 32'(dct_count), 32'd16);
    chk("t3_ovf", 32'(overflow), 32'd1);
    drain("t3_pop", 0, 16);

    // 4: word in the trigger cycle is pre-trigger
    do_arm();
    dct_valid = 1'b1; dct_word = 30'hAA; test_ending = 1'b1;
    tick();
    dct_valid = 1'b0; test_ending = 1'b0;
    chk("t4_post", 32'(state), 32'd2);
    chk("t4_cnt_aa", 32'(dct_count), 32'd1);
    for (int i = 0; i < 3; i++) wr(30'hB0 + 30'(i));
    chk("t4_still_post", 32'(state), 32'd2);
    wr(30'hB3);
    chk("t4_state", 32'(state), 32'd3);
    chk("t4_cnt", 32'(dct_count), 32'd5);
    drain("t4_pop_aa", 'hAA, 1);
    drain("t4_pop_b", 'hB0, 4);

    // 5: re-arm inside the post window
    do_arm();
    for (int i = 0; i < 17; i++) wr(30'(i));
    chk("t5_ovf_set", 32'(overflow), 32'd1);
    trig();
    wr(30'h30);
    wr(30'h31);
    rd_en = 1'b1; test_ending = 1'b1;
    do_arm();
    rd_en = 1'b0; test_ending = 1'b0;
    chk("t5_state", 32'(state), 32'd1);
    chk("t5_cnt", 32'(dct_count), 32'd0);
    chk("t5_ovf", 32'(overflow), 32'd0);
    chk("t5_ended", 32'(test_has_ended), 32'd0);
    chk("t5_no_rd", 32'(rd_valid), 32'd0);
    wr(30'h55);
    trig();
    for (int i = 0; i < 4; i++) wr(30'h60 + 30'(i));
    chk("t5_cnt5", 32'(dct_count), 32'd5);
    drain("t5_pop", 'h55, 1);

    // 6: async reset between pops
    rd_en = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("t6_state", 32'(state), 32'd0);
    chk("t6_cnt", 32'(dct_count), 32'd0);
    chk("t6_ended", 32'(test_has_ended), 32'd0);
    chk("t6_rdata", 32'(rd_data), 32'd0);
    chk("t6_buf", 32'(dct_buffer), 32'd0);
    tick();
    chk("t6_vld_in_rst", 32'(rd_valid), 32'd0);
    reset = 1'b0;
    tick();
    chk("t6_vld_after", 32'(rd_valid), 32'd0);
    chk("t6_idle", 32'(state), 32'd0);
    rd_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
